// File: rtl/irq_hub_pkg.sv
// irq_hub_pkg
//   Shared definitions for the interrupt hub: register map, handshake FSM
//   state encoding and the width of the tick divider.
//   No ports.
package irq_hub_pkg;

    localparam logic [1:0] REG_MASK = 2'd0;
    localparam logic [1:0] REG_PEND = 2'd1;
    localparam logic [1:0] REG_MODE = 2'd2;
    localparam logic [1:0] REG_TICK = 2'd3;

    localparam int TICK_CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_tick_gen.sv
// irq_tick_gen
//   Periodic tick source. A counter runs 0..div_i-1 and tick_o pulses for
//   one cycle each time it wraps. div_i = 0 parks the counter and silences
//   the tick; restart_i forces the counter back to 0.
// Ports:
//   clk_i      system clock
//   rst_i      synchronous active-high reset
//   div_i      period in clock cycles (0 = off)
//   restart_i  restart the count from 0
//   tick_o     one-cycle pulse per period (registered)
module irq_tick_gen
    import irq_hub_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [TICK_CNT_W-1:0] div_i,
    input  logic                  restart_i,
    output logic                  tick_o
);

    logic [TICK_CNT_W-1:0] cnt_q, cnt_d;
    logic                  tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (restart_i || (div_i == '0)) begin
            cnt_d = '0;
        end else if (cnt_q >= div_i - 1'b1) begin
            // >= rather than == so that shrinking div_i below the running
            // count wraps immediately instead of counting through 2^32.
            cnt_d  = '0;
            tick_d = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/irq_hub.sv
// irq_hub
//   Interrupt aggregator: NUM_IRQ maskable sources, each edge- or
//   level-triggered, presented to the CPU as one fixed-priority vector
//   (lowest index wins) over a req/ack handshake. Programmed through a
//   4-entry register port (MASK, PENDING, MODE, TICK_DIV).
//   Build option IRQ_HUB_TICK_EN: source NUM_IRQ-1 is driven by an internal
//   periodic tick (irq_tick_gen) instead of src_i[NUM_IRQ-1].
//
//   state | meaning
//   IDLE  | no request outstanding, waiting for an enabled pending source
//   REQ   | irq_req_o high, irq_vec_o frozen until irq_ack_i
//   GAP   | one cycle with irq_req_o low after an ack, then re-evaluate
//
// Ports:
//   clk_i      system clock
//   rst_i      synchronous active-high reset
//   src_i      interrupt source lines
//   irq_req_o  request to the CPU
//   irq_vec_o  index of the requested source (valid with irq_req_o)
//   irq_ack_i  CPU acknowledge, single-cycle pulse
//   wr_i       register write strobe
//   addr_i     register select
//   wdata_i    write data
//   rdata_o    registered read data
module irq_hub
    import irq_hub_pkg::*;
#(
    parameter int NUM_IRQ = 8,
`ifdef IRQ_HUB_TICK_EN
    parameter int unsigned TICK_DIV_RST = 50000,
`endif
    localparam int VEC_W = $clog2(NUM_IRQ)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_IRQ-1:0] src_i,
    output logic               irq_req_o,
    output logic [VEC_W-1:0]   irq_vec_o,
    input  logic               irq_ack_i,
    input  logic               wr_i,
    input  logic [1:0]         addr_i,
    input  logic [31:0]        wdata_i,
    output logic [31:0]        rdata_o
);

    irq_state_e         state_q, state_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [NUM_IRQ-1:0] mask_q, mode_q, pending_q, src_q;
    logic [NUM_IRQ-1:0] mask_d, mode_d, pending_d;
    logic [31:0]        rdata_q, rdata_d;

    logic [NUM_IRQ-1:0] rise, mode_eff, clr, eff_set;
    logic [VEC_W-1:0]   win_idx;
    logic               win_vld;
    logic               ack_fire;

    logic               wr_mask, wr_pend, wr_mode, wr_tick;

    assign wr_mask = wr_i && (addr_i == REG_MASK);
    assign wr_pend = wr_i && (addr_i == REG_PEND);
    assign wr_mode = wr_i && (addr_i == REG_MODE);
    assign wr_tick = wr_i && (addr_i == REG_TICK);

    // Sinks bits that some builds leave unread (upper wdata bits, the
    // external line shadowed by the tick source).
    logic unused_bits;
    assign unused_bits = ^{wdata_i, src_i, src_q};

    // ---------------------------------------------------------------
    // Tick source
    // ---------------------------------------------------------------
`ifdef IRQ_HUB_TICK_EN
    logic [TICK_CNT_W-1:0] tick_div_q;
    logic                  tick;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tick_div_q <= TICK_CNT_W'(TICK_DIV_RST);
        end else if (wr_tick) begin
            tick_div_q <= wdata_i;
        end
    end

    irq_tick_gen u_tick (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .div_i     (tick_div_q),
        .restart_i (wr_tick),
        .tick_o    (tick)
    );
`else
    logic unused_wr_tick;
    assign unused_wr_tick = wr_tick;
`endif

    // ---------------------------------------------------------------
    // Source conditioning and pending bits
    // ---------------------------------------------------------------
    always_comb begin
        rise     = src_i & ~src_q;
        mode_eff = mode_q;
`ifdef IRQ_HUB_TICK_EN
        // The tick is already a one-cycle pulse; use it directly as the set
        // event so back-to-back ticks (TICK_DIV=1) are not merged.
        rise[NUM_IRQ-1]     = tick;
        mode_eff[NUM_IRQ-1] = 1'b0;
`endif
    end

    assign ack_fire = (state_q == REQ) && irq_ack_i;

    always_comb begin
        clr = '0;
        if (ack_fire) begin
            clr[vec_q] = 1'b1;
        end
        if (wr_pend) begin
            clr = clr | wdata_i[NUM_IRQ-1:0];
        end
        // Set after clear: a fresh edge survives a same-cycle clear.
        // Level bits simply track the line and ignore clears.
        pending_d = (mode_eff & src_i) | (~mode_eff & ((pending_q & ~clr) | rise));
    end

    assign mask_d = wr_mask ? wdata_i[NUM_IRQ-1:0] : mask_q;
    assign mode_d = wr_mode ? wdata_i[NUM_IRQ-1:0] : mode_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            src_q     <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            mode_q    <= '0;
        end else begin
            src_q     <= src_i;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            mode_q    <= mode_d;
        end
    end

    // ---------------------------------------------------------------
    // Fixed priority: lowest index wins
    // ---------------------------------------------------------------
    assign eff_set = pending_q & mask_q;
    assign win_vld = |eff_set;

    always_comb begin
        win_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eff_set[i]) begin
                win_idx = VEC_W'(i);
            end
        end
    end

    // ---------------------------------------------------------------
    // Handshake FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        case (state_q)
            // GAP re-evaluates directly so the next request can follow the
            // single low cycle without an extra IDLE cycle.
            IDLE, GAP: begin
                if (win_vld) begin
                    state_d = REQ;
                    vec_d   = win_idx;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (irq_ack_i) begin
                    state_d = GAP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        irq_req_o = (state_q == REQ);
        irq_vec_o = vec_q;
    end

    // ---------------------------------------------------------------
    // Register read port
    // ---------------------------------------------------------------
    always_comb begin
        rdata_d = '0;
        case (addr_i)
            REG_MASK: rdata_d[NUM_IRQ-1:0] = mask_q;
            REG_PEND: rdata_d[NUM_IRQ-1:0] = pending_q;
            REG_MODE: rdata_d[NUM_IRQ-1:0] = mode_q;
`ifdef IRQ_HUB_TICK_EN
            REG_TICK: rdata_d = tick_div_q;
`endif
            default:  rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_irq_hub.sv
module tb_irq_hub;

    localparam int N = 8;

`ifdef IRQ_HUB_TICK_EN
    localparam logic [31:0] TICK_RST_EXP = 32'd50000;
`else
    localparam logic [31:0] TICK_RST_EXP = 32'd0;
`endif

    logic         clk;
    logic         rst;
    logic [N-1:0] src;
    logic         irq_req;
    logic [2:0]   irq_vec;
    logic         irq_ack;
    logic         wr;
    logic [1:0]   addr;
    logic [31:0]  wdata;
    logic [31:0]  rdata;

    int compared   = 0;
    int mismatched = 0;

    irq_hub #(.NUM_IRQ(N)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .src_i     (src),
        .irq_req_o (irq_req),
        .irq_vec_o (irq_vec),
        .irq_ack_i (irq_ack),
        .wr_i      (wr),
        .addr_i    (addr),
        .wdata_i   (wdata),
        .rdata_o   (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        wr = 1'b1; addr = a; wdata = d;
        step(1);
        wr = 1'b0; wdata = '0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        step(1);
        d = rdata;
    endtask

    logic [31:0] rd;
    int          t_prev;
    int          n_iv;
    int          n_req;

    initial begin
        rst = 1'b1; src = '0; irq_ack = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        step(2);
        rst = 1'b0;

        // ---------------- reset state ----------------
        check("rst_req", {31'd0, irq_req}, 32'd0);
        check("rst_vec", {29'd0, irq_vec}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        reg_read(2'd0, rd); check("rst_mask", rd, 32'h0);
        reg_read(2'd1, rd); check("rst_pend", rd, 32'h0);
        reg_read(2'd2, rd); check("rst_mode", rd, 32'h0);
        reg_read(2'd3, rd); check("rst_tick", rd, TICK_RST_EXP);

        // ---------------- priority ----------------
        reg_write(2'd0, 32'hFF);
        reg_read(2'd0, rd); check("mask_rb", rd, 32'hFF);
        src = 8'h24;
        step(1);
        check("prio_req_n1", {31'd0, irq_req}, 32'd0);
        step(1);
        src = 8'h00;
        check("prio_req_n2", {31'd0, irq_req}, 32'd1);
        check("prio_vec_first", {29'd0, irq_vec}, 32'd2);
        step(1);
        check("prio_hold_req", {31'd0, irq_req}, 32'd1);
        check("prio_hold_vec", {29'd0, irq_vec}, 32'd2);
        irq_ack = 1'b1; step(1); irq_ack = 1'b0;
        check("prio_gap", {31'd0, irq_req}, 32'd0);
        step(1);
        check("prio_req2", {31'd0, irq_req}, 32'd1);
        check("prio_vec_second", {29'd0, irq_vec}, 32'd5);
        irq_ack = 1'b1; step(1); irq_ack = 1'b0;
        check("prio_gap2", {31'd0, irq_req}, 32'd0);
        step(1);
        check("prio_idle", {31'd0, irq_req}, 32'd0);
        reg_read(2'd1, rd); check("prio_pend_empty", rd, 32'h0);

        // ---------------- masking / W1C / stray ack ----------------
        reg_write(2'd0, 32'h00);
        src = 8'h08; step(2); src = 8'h00;
        check("mask_no_req", {31'd0, irq_req}, 32'd0);
        reg_read(2'd1, rd); check("mask_pend", rd, 32'h08);
        src = 8'h40; step(1); src = 8'h00;
        irq_ack = 1'b1; step(1); irq_ack = 1'b0;
        reg_read(2'd1, rd); check("stray_ack_pend", rd, 32'h48);
        reg_write(2'd1, 32'h40);
        reg_read(2'd1, rd); check("w1c_pend", rd, 32'h08);
        reg_write(2'd0, 32'h08);
        check("unmask_req_n1", {31'd0, irq_req}, 32'd0);
        step(1);
        check("unmask_req_n2", {31'd0, irq_req}, 32'd1);
        check("unmask_vec", {29'd0, irq_vec}, 32'd3);
        reg_write(2'd0, 32'h00);
        check("mask_in_req_hold", {31'd0, irq_req}, 32'd1);
        irq_ack = 1'b1; step(1); irq_ack = 1'b0;
        check("unmask_gap", {31'd0, irq_req}, 32'd0);
        reg_read(2'd1, rd); check("unmask_pend_clr", rd, 32'h0);

        // ---------------- level mode ----------------
        reg_write(2'd2, 32'h02);
        reg_write(2'd0, 32'h02);
        src = 8'h02;
        step(2);
        check("lvl_req", {31'd0, irq_req}, 32'd1);
        check("lvl_vec", {29'd0, irq_vec}, 32'd1);
        irq_ack = 1'b1; step(1); irq_ack = 1'b0;
        check("lvl_gap", {31'd0, irq_req}, 32'd0);
        step(1);
        check("lvl_reassert", {31'd0, irq_req}, 32'd1);
        check("lvl_vec2", {29'd0, irq_vec}, 32'd1);
        src = 8'h00;
        irq_ack = 1'b1; step(1); irq_ack = 1'b0;
        check("lvl_gap2", {31'd0, irq_req}, 32'd0);
        step(1);
        check("lvl_low_noreq", {31'd0, irq_req}, 32'd0);
        reg_read(2'd1, rd); check("lvl_low_pend", rd, 32'h0);
        reg_read(2'd2, rd); check("mode_rb", rd, 32'h02);

        // ---------------- race: set beats ack-clear ----------------
        reg_write(2'd2, 32'h00);
        reg_write(2'd0, 32'h10);
        src = 8'h10; step(1); src = 8'h00; step(1);
        check("race_req", {31'd0, irq_req}, 32'd1);
        check("race_vec", {29'd0, irq_vec}, 32'd4);
        src = 8'h10; irq_ack = 1'b1; step(1); irq_ack = 1'b0; src = 8'h00;
        check("race_gap", {31'd0, irq_req}, 32'd0);
        reg_read(2'd1, rd); check("race_pend", rd, 32'h10);
        check("race_reassert", {31'd0, irq_req}, 32'd1);
        check("race_vec2", {29'd0, irq_vec}, 32'd4);
        irq_ack = 1'b1; step(1); irq_ack = 1'b0;
        step(1);
        check("race_done", {31'd0, irq_req}, 32'd0);

`ifdef IRQ_HUB_TICK_EN
        // ---------------- tick ----------------
        reg_write(2'd0, 32'h80);
        reg_write(2'd3, 32'd10);
        t_prev = -1; n_iv = 0;
        for (int c = 0; c < 60; c++) begin
            irq_ack = irq_req;
            if (irq_req) begin
                if (t_prev >= 0 && n_iv < 3) begin
                    check("tick_period", c - t_prev, 32'd10);
                    check("tick_vec", {29'd0, irq_vec}, 32'd7);
                    n_iv++;
                end
                t_prev = c;
            end
            step(1);
        end
        irq_ack = 1'b0;
        check("tick_count", n_iv, 32'd3);
        reg_write(2'd3, 32'd0);
        step(2);
        irq_ack = irq_req; step(1); irq_ack = 1'b0;
        step(1);
        n_req = 0;
        for (int c = 0; c < 30; c++) begin
            if (irq_req) n_req++;
            step(1);
        end
        check("tick_stopped", n_req, 32'd0);
`endif

        // ---------------- reset during REQ ----------------
        reg_write(2'd0, 32'h04);
        src = 8'h05; step(2);
        check("rstreq_req", {31'd0, irq_req}, 32'd1);
        check("rstreq_vec", {29'd0, irq_vec}, 32'd2);
        rst = 1'b1; src = 8'h00; step(1); rst = 1'b0;
        check("rstreq_req_low", {31'd0, irq_req}, 32'd0);
        check("rstreq_vec_zero", {29'd0, irq_vec}, 32'd0);
        check("rstreq_rdata", rdata, 32'd0);
        reg_read(2'd1, rd); check("rstreq_pend", rd, 32'h0);
        reg_read(2'd0, rd); check("rstreq_mask", rd, 32'h0);
        reg_read(2'd3, rd); check("rstreq_tick", rd, TICK_RST_EXP);
        step(2);
        check("rstreq_stay_idle", {31'd0, irq_req}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/irq_hub.md
# irq_hub

Parametrised interrupt aggregator for the CPU, replacing the fixed irq1..irq7 wiring with NUM_IRQ configurable sources. Each source is independently maskable and selectable as edge- or level-triggered. The hub presents one prioritised vector to the CPU over a request/acknowledge handshake and is programmed by the CPU through a small register port. An optional built-in periodic tick source replaces the external clock-divider interrupt.

## Interface
- NUM_IRQ, 8: number of interrupt sources, 2..32.
- VEC_W, $clog2(NUM_IRQ): vector width (derived localparam).
- TICK_DIV_RST, 50000: reset value of the tick divider register (tick builds only).
- clk  in  1  system clock; single clock domain; all sources synchronous to it.
- rst  in  1  reset, synchronous, active-high.
- src  in  NUM_IRQ  interrupt source lines.
- irq_req  out  1  interrupt request to the CPU.
- irq_vec  out  VEC_W  index of the requested source; valid while irq_req=1.
- irq_ack  in  1  CPU acknowledge; single-cycle pulse.
- wr  in  1  register write strobe.
- addr  in  2  register select.
- wdata  in  32  write data.
- rdata  out  32  read data, registered.

## Operation
- Registers:
  - addr 0 MASK: read/write; bit i=1 enables source i.
  - addr 1 PENDING: read; writing 1 to a bit clears it.
  - addr 2 MODE: read/write; bit i=1 selects level mode for source i.
  - addr 3 TICK_DIV: read/write.
  - Bits at or above NUM_IRQ read as 0 and ignore writes.
- Edge mode: src is registered once. A rising edge (src & ~src_q) sets pending[i].
- Level mode: pending[i] mirrors src[i] each cycle. Ack and write-1-to-clear have no lasting effect; the source itself must be cleared.
- Effective set = pending & MASK. Priority is fixed: the lowest index wins.
- FSM:
  - IDLE: if the effective set is non-zero, latch the winner into irq_vec, set irq_req=1, go to REQ.
  - REQ: irq_req and irq_vec are held stable until irq_ack. On ack, clear pending[irq_vec] (edge mode only) and go to GAP. Masking the source while in REQ does not withdraw the request.
  - GAP: irq_req=0 for exactly one cycle, then go to IDLE and re-evaluate.
- irq_ack outside REQ is ignored.
- Simultaneous events on the same bit: a new rising edge (set) beats both ack-clear and write-1-to-clear, so the event is kept pending.
- A write to MASK or MODE takes effect in the cycle after the write.

## Timing
- Reset values:
  - irq_req=0, irq_vec=0, rdata=0.
  - MASK=0, PENDING=0, MODE=0, TICK_DIV=TICK_DIV_RST.
  - src_q=0, FSM state=IDLE, tick counter=0.
- Source edge at cycle n: pending is set at n+1, irq_req rises at n+2 (IDLE, source enabled).
- Ack at cycle n: irq_req=0 at n+1 (GAP). The earliest next request is at n+2.
- Read: rdata reflects the register selected by addr one cycle after addr is presented. Reads have no side effects.
- Reset mid-handshake: the FSM returns to IDLE and all pending bits are lost.

## Configuration
- IRQ_HUB_TICK_EN defined:
  - Source NUM_IRQ-1 is internal. It pulses one cycle each time a counter running 0..TICK_DIV-1 wraps, and the external src[NUM_IRQ-1] is ignored.
  - TICK_DIV=0 stops the tick.
  - Writing TICK_DIV resets the counter to 0.
  - The tick line is always treated as edge mode.
- IRQ_HUB_TICK_EN undefined: all NUM_IRQ sources are external, TICK_DIV reads 0 and ignores writes, and no counter is synthesised.

## Structure
- Package irq_hub_pkg holds:
  - register address constants: REG_MASK=0, REG_PEND=1, REG_MODE=2, REG_TICK=3;
  - FSM state enum: IDLE, REQ, GAP;
  - TICK_DIV counter width constant: 32.
- Sub-module irq_tick_gen (clk, rst, div, restart, tick) implements the divider. It is instantiated only under IRQ_HUB_TICK_EN.

## Test plan
- Priority: NUM_IRQ=8, MASK=0xFF, rising edges on src[5] and src[2] in the same cycle -> irq_vec=2 first; after ack, GAP for one cycle, then irq_vec=5.
- Masking: MASK=0x00, edge on src[3] -> PENDING reads 0x08 and irq_req stays 0. Then write MASK=0x08 -> irq_req=1 two cycles later with irq_vec=3.
- Level mode: MODE=0x02, MASK=0x02, src[1] held high -> after ack, irq_req re-asserts after the one-cycle GAP. With src[1] low, PENDING[1]=0 and there is no request.
- Race on clear: ack for vec 4 in the same cycle as a new rising edge on src[4] -> PENDING[4] stays 1 and irq_req re-asserts with irq_vec=4.
- Tick (macro on): TICK_DIV=10, MASK bit 7 set -> pending[7] is set once every 10 cycles. Writing TICK_DIV=0 stops the ticks.
- Reset during REQ: assert rst for one cycle -> next cycle irq_req=0 and PENDING=0; TICK_DIV is restored to TICK_DIV_RST in tick builds and reads 0 otherwise.
